// File: rtl/fir_bank_pwm_if.sv
// Sample stream, coefficient port and result/indicator bundle.
// master drives samples and coefficients; slave is the filter bank.
interface fir_bank_pwm_if #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int TAPS     = 512,
    parameter int CHANNELS = 4
);
    localparam int TW    = $clog2(TAPS);
    localparam int CW    = $clog2(CHANNELS);
    localparam int ACC_W = DATA_W + COEF_W + TW;

    logic                      s_valid;
    logic [DATA_W-1:0]         s_data;
    logic                      s_ready;
    logic                      coef_we;
    logic [CW+TW-1:0]          coef_addr;
    logic [COEF_W-1:0]         coef_data;
    logic                      y_valid;
    logic [CHANNELS*ACC_W-1:0] y_data;
    logic [CHANNELS-1:0]       pwm_out;
    logic                      overrun;
    logic                      coef_err;

    modport master (
        output s_valid, s_data, coef_we, coef_addr, coef_data,
        input  s_ready, y_valid, y_data, pwm_out, overrun, coef_err
    );

    modport slave (
        input  s_valid, s_data, coef_we, coef_addr, coef_data,
        output s_ready, y_valid, y_data, pwm_out, overrun, coef_err
    );
endinterface

// File: rtl/fir_bank_pwm.sv
// Time-multiplexed multi-channel FIR bank, one MAC per clock,
// with a rectified, scaled PWM level indicator per channel.
module fir_bank_pwm #(
    parameter int DATA_W     = 16,
    parameter int COEF_W     = 16,
    parameter int TAPS       = 512,
    parameter int CHANNELS   = 4,
    parameter int PWM_W      = 11,
    parameter int PWM_SHIFT  = 20,
    parameter int PWM_THRESH = 8
) (
    input  logic          clk,
    input  logic          reset,
    fir_bank_pwm_if.slave bus
);
    localparam int TW    = $clog2(TAPS);
    localparam int CW    = $clog2(CHANNELS);
    localparam int AW    = CW + TW;
    localparam int N     = CHANNELS * TAPS;
    localparam int PW    = DATA_W + COEF_W;
    localparam int ACC_W = PW + TW;
    localparam int CHW   = (CW > 0) ? CW : 1;

    localparam logic [ACC_W-1:0] MAG_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] Y_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] LVL_CAP = ACC_W'((1 << PWM_W) - 1);

    typedef enum logic [1:0] {CLEAR, IDLE, RUN, FLUSH} state_t;

    state_t state, state_nx;

    logic [AW-1:0] idx;
    logic [TW-1:0] wr_ptr;
    logic [TW-1:0] head;
    logic          accept;
    logic          last_idx;

    logic signed [COEF_W-1:0] coef_mem [N];
    logic signed [DATA_W-1:0] samp_mem [TAPS];

    logic                     coef_we_i;
    logic [AW-1:0]            coef_wa;
    logic signed [COEF_W-1:0] coef_wd;
    logic                     samp_we;
    logic [TW-1:0]            samp_wa;
    logic signed [DATA_W-1:0] samp_wd;
    logic [TW-1:0]            samp_ra;

    logic signed [COEF_W-1:0] rd_coef;
    logic signed [DATA_W-1:0] rd_samp;
    logic                     p1_vld;
    logic                     p1_first;
    logic                     p1_last;
    logic [CHW-1:0]           p1_ch;
    logic                     p2_vld;
    logic [CHW-1:0]           p2_ch;

    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc;

    logic [CHANNELS*ACC_W-1:0] y_shadow;
    logic [CHANNELS*ACC_W-1:0] y_next;
    logic [CHANNELS*ACC_W-1:0] y_data_q;
    logic                      y_valid_q;

    logic [PWM_W-1:0]    cnt;
    logic [CHANNELS-1:0] pwm_nx;
    logic [CHANNELS-1:0] pwm_q;
    logic                overrun_q;
    logic                coef_err_q;

    assign accept   = (state == IDLE) && bus.s_valid;
    assign last_idx = &idx;

    // Next-state decode; FLUSH ends on the result pulse itself.
    always_comb begin
        state_nx = state;
        unique case (state)
            CLEAR:   if (last_idx) state_nx = IDLE;
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (last_idx) state_nx = FLUSH;
            FLUSH:   if (y_valid_q) state_nx = IDLE;
            default: state_nx = CLEAR;
        endcase
    end

    // State, MAC index and sample write pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= CLEAR;
            idx    <= '0;
            wr_ptr <= '0;
            head   <= '0;
        end else begin
            state <= state_nx;
            if (state == CLEAR || state == RUN) begin
                idx <= idx + AW'(1);
            end else begin
                idx <= '0;
            end
            if (accept) begin
                head   <= wr_ptr;
                wr_ptr <= wr_ptr + TW'(1);
            end
        end
    end

    // RAM write ports: CLEAR zero-fill, otherwise IDLE traffic.
    always_comb begin
        coef_we_i = 1'b0;
        coef_wa   = bus.coef_addr;
        coef_wd   = bus.coef_data;
        samp_we   = 1'b0;
        samp_wa   = wr_ptr;
        samp_wd   = bus.s_data;
        if (state == CLEAR) begin
            coef_we_i = 1'b1;
            coef_wa   = idx;
            coef_wd   = '0;
            samp_we   = 1'b1;
            samp_wa   = idx[TW-1:0];
            samp_wd   = '0;
        end else if (state == IDLE) begin
            coef_we_i = bus.coef_we;
            samp_we   = bus.s_valid;
        end
    end

    // Coefficient and sample storage.
    always_ff @(posedge clk) begin
        if (coef_we_i) coef_mem[coef_wa] <= coef_wd;
        if (samp_we) samp_mem[samp_wa] <= samp_wd;
    end

    assign samp_ra = head - idx[TW-1:0];

    // Registered RAM reads, the first pipeline stage.
    always_ff @(posedge clk) begin
        rd_coef <= coef_mem[idx];
        rd_samp <= samp_mem[samp_ra];
    end

    // Pipeline tags that travel alongside the read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            p1_vld   <= 1'b0;
            p1_first <= 1'b0;
            p1_last  <= 1'b0;
            p1_ch    <= '0;
            p2_vld   <= 1'b0;
            p2_ch    <= '0;
        end else begin
            p1_vld   <= (state == RUN);
            p1_first <= (idx[TW-1:0] == '0);
            p1_last  <= &idx[TW-1:0];
            p1_ch    <= CHW'(idx >> TW);
            p2_vld   <= p1_vld && p1_last;
            p2_ch    <= p1_ch;
        end
    end

    assign prod     = PW'(rd_coef) * PW'(rd_samp);
    assign prod_ext = ACC_W'(prod);

    // MAC: reload on a channel's first tap, accumulate afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (p1_vld) begin
            acc <= p1_first ? prod_ext : acc + prod_ext;
        end
    end

    // Slot the finished channel into the pending result word.
    always_comb begin
        y_next = y_shadow;
        y_next[int'(p2_ch)*ACC_W +: ACC_W] = acc;
    end

    // Collect channel results; publish all together after the last one.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_shadow  <= '0;
            y_data_q  <= '0;
            y_valid_q <= 1'b0;
        end else begin
            y_valid_q <= 1'b0;
            if (p2_vld) begin
                y_shadow <= y_next;
                if (p2_ch == CHW'(CHANNELS - 1)) begin
                    y_data_q  <= y_next;
                    y_valid_q <= 1'b1;
                end
            end
        end
    end

    // Sticky drop flag and rejected-write pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q  <= 1'b0;
            coef_err_q <= 1'b0;
        end else begin
            if (bus.s_valid && state != IDLE) overrun_q <= 1'b1;
            coef_err_q <= bus.coef_we && (state != IDLE);
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [ACC_W-1:0] yc;
        logic [ACC_W-1:0] mag;
        logic [ACC_W-1:0] shf;
        logic [PWM_W-1:0] lvl_nx;
        logic [PWM_W-1:0] lvl;

        assign yc     = y_data_q[c*ACC_W +: ACC_W];
        assign mag    = (yc == Y_MIN) ? MAG_MAX :
                        (yc[ACC_W-1] ? -yc : yc);
        assign shf    = mag >> PWM_SHIFT;
        assign lvl_nx = (shf > LVL_CAP) ? '1 : shf[PWM_W-1:0];
        assign pwm_nx[c] = (lvl > PWM_W'(PWM_THRESH)) && (cnt < lvl);

        // Latch the indicator level whenever fresh results appear.
        always_ff @(posedge clk) begin
            if (reset) begin
                lvl <= '0;
            end else if (y_valid_q) begin
                lvl <= lvl_nx;
            end
        end
    end

    // Free-running PWM counter and registered PWM outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            pwm_q <= '0;
        end else begin
            cnt   <= cnt + PWM_W'(1);
            pwm_q <= pwm_nx;
        end
    end

    assign bus.s_ready  = (state == IDLE);
    assign bus.y_valid  = y_valid_q;
    assign bus.y_data   = y_data_q;
    assign bus.pwm_out  = pwm_q;
    assign bus.overrun  = overrun_q;
    assign bus.coef_err = coef_err_q;

endmodule
